imem_loader: RTL and testbench

Writer side of the instruction-memory interface. The pipeline core only reads the 64K x 32-bit instruction memory. This block fills that memory from a byte-serial boot/debug stream: it parses a framed download, assembles big-endian 32-bit words and issues single-cycle word writes. It also holds the core while a download is in progress.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_word_assembler.sv | 49 ++++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame: ADDR(2) CNT(2) N*4 data bytes, then an XOR checksum byte.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_CSUM,
        ST_FIN
    } imem_ld_state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler.
// o_word/o_word_valid are registered: valid the cycle after the 4th byte.
module imem_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic              o_last_byte,
    output logic              o_word_valid,
    output logic [DATA_W-1:0] o_word
);

    logic [1:0]        r_idx;
    logic [DATA_W-9:0] r_shift;
    logic              r_valid;
    logic [DATA_W-1:0] r_word;

    assign o_last_byte  = i_byte_en && (r_idx == LAST_BYTE_IDX);
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_idx   <= '0;
                r_shift <= '0;
            end else if (i_byte_en) begin
                r_idx   <= r_idx + 2'd1;
                r_shift <= {r_shift[DATA_W-17:0], i_byte};
                if (o_last_byte) begin
                    r_word  <= {r_shift, i_byte};
                    r_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-serial framed loader that writes the instruction memory
// and holds the core while a download is in progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    imem_ld_state_t r_state;
    imem_ld_state_t w_next;

    logic [15:0]       r_base;
    logic [15:0]       r_cnt;
    logic [15:0]       r_widx;
    logic [7:0]        r_csum;
    logic              r_err;
    logic [ADDR_W-1:0] r_wr_addr;

    logic w_accept;
    logic w_start_ok;
    logic w_data_byte;
    logic w_last_byte;
    logic w_last_word;
    logic w_cnt_zero;

    assign in_ready = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign busy     = (r_state != ST_IDLE);
    assign cpu_hold = busy;
    assign done     = (r_state == ST_FIN);
    assign err      = r_err;
    assign wr_addr  = r_wr_addr;

    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && (r_state == ST_IDLE);
    assign w_data_byte = w_accept && (r_state == ST_DATA);
    assign w_last_word = w_last_byte && ((r_widx + 16'd1) == r_cnt);
    assign w_cnt_zero  = ({r_cnt[15:8], in_data} == 16'd0);

    imem_word_assembler #(
        .DATA_W(DATA_W)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_byte_en   (w_data_byte),
        .i_byte      (in_data),
        .o_last_byte (w_last_byte),
        .o_word_valid(wr_en),
        .o_word      (wr_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (start)    w_next = ST_ADDR_HI;
            ST_ADDR_HI: if (w_accept) w_next = ST_ADDR_LO;
            ST_ADDR_LO: if (w_accept) w_next = ST_CNT_HI;
            ST_CNT_HI:  if (w_accept) w_next = ST_CNT_LO;
            ST_CNT_LO: begin
                if (w_accept) begin
                    w_next = w_cnt_zero ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA:    if (w_last_word) w_next = ST_CSUM;
            ST_CSUM:    if (w_accept)    w_next = ST_FIN;
            ST_FIN:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base    <= '0;
            r_cnt     <= '0;
            r_widx    <= '0;
            r_csum    <= '0;
            r_err     <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            if (w_start_ok) begin
                r_csum <= '0;
                r_err  <= 1'b0;
                r_widx <= '0;
            end else if (w_accept) begin
                if (r_state != ST_CSUM) begin
                    r_csum <= r_csum ^ in_data;
                end
                unique case (r_state)
                    ST_ADDR_HI: r_base[15:8] <= in_data;
                    ST_ADDR_LO: r_base[7:0]  <= in_data;
                    ST_CNT_HI:  r_cnt[15:8]  <= in_data;
                    ST_CNT_LO:  r_cnt[7:0]   <= in_data;
                    ST_CSUM:    r_err        <= (in_data != r_csum);
                    default:    ;
                endcase
                // Address wraps modulo 2^ADDR_W by truncation.
                if (w_last_byte) begin
                    r_wr_addr <= ADDR_W'(r_base + r_widx);
                    r_widx    <= r_widx + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Writes are captured at negedge and compared against hand-built frames.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    int errors = 0;
    int checks = 0;
    int hold_bad = 0;
    logic [47:0] wq[$];

    imem_loader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .busy    (busy),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
        if (cpu_hold !== busy) hold_bad++;
    end

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gaps,
                        input bit pulse_start);
        in_valid = 1'b0;
        repeat (gaps) tick();
        start = pulse_start;
        chk("in_ready", {47'd0, in_ready}, 48'd1);
        chk("cpu_hold", {47'd0, cpu_hold}, 48'd1);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit jitter,
                              input int start_at);
        foreach (f[i]) begin
            send(f[i], jitter ? int'($urandom_range(0, 2)) : 0,
                 (i == start_at));
        end
    endtask

    task automatic end_frame(input bit exp_err, input bit fin_start);
        chk("done_fin", {47'd0, done}, 48'd1);
        chk("err_fin", {47'd0, err}, {47'd0, exp_err});
        chk("busy_fin", {47'd0, busy}, 48'd1);
        start = fin_start;
        tick();
        start = 1'b0;
        chk("done_after", {47'd0, done}, 48'd0);
        chk("busy_after", {47'd0, busy}, 48'd0);
        chk("err_after", {47'd0, err}, {47'd0, exp_err});
    endtask

    logic [7:0] f_basic[$];
    logic [7:0] f_empty[$];
    logic [7:0] f_bad[$];
    logic [7:0] f_wrap[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        f_basic = '{8'h00, 8'h10, 8'h00, 8'h01,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33};
        f_empty = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
        f_bad   = '{8'h00, 8'h10, 8'h00, 8'h01,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h34};
        f_wrap  = '{8'hFF, 8'hFF, 8'h00, 8'h02,
                    8'h11, 8'h11, 8'h11, 8'h11,
                    8'h22, 8'h22, 8'h22, 8'h22, 8'h02};

        repeat (3) tick();
        chk("rst_flags", {42'd0, in_ready, busy, cpu_hold, done, err, wr_en},
            48'd0);
        chk("rst_bus", {wr_addr, wr_data}, 48'd0);
        rst = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        tick();
        chk("idle_ignore", {46'd0, busy, in_ready}, 48'd0);
        in_valid = 1'b0;

        wq.delete();
        do_start();
        chk("busy_start", {47'd0, busy}, 48'd1);
        send_frame(f_basic, 1'b0, -1);
        end_frame(1'b0, 1'b0);
        chk("basic_n", 48'(wq.size()), 48'd1);
        if (wq.size() > 0) chk("basic_w0", wq[0], {16'h0010, 32'hDEADBEEF});

        wq.delete();
        do_start();
        send_frame(f_empty, 1'b0, -1);
        end_frame(1'b0, 1'b0);
        chk("empty_n", 48'(wq.size()), 48'd0);

        wq.delete();
        do_start();
        send_frame(f_bad, 1'b0, -1);
        end_frame(1'b1, 1'b1);
        chk("bad_n", 48'(wq.size()), 48'd1);
        if (wq.size() > 0) chk("bad_w0", wq[0], {16'h0010, 32'hDEADBEEF});
        tick();
        chk("err_sticky", {47'd0, err}, 48'd1);
        do_start();
        chk("err_clear", {47'd0, err}, 48'd0);
        send_frame(f_empty, 1'b0, -1);
        end_frame(1'b0, 1'b0);

        wq.delete();
        do_start();
        send_frame(f_wrap, 1'b0, -1);
        end_frame(1'b0, 1'b0);
        chk("wrap_n", 48'(wq.size()), 48'd2);
        if (wq.size() > 1) begin
            chk("wrap_w0", wq[0], {16'hFFFF, 32'h11111111});
            chk("wrap_w1", wq[1], {16'h0000, 32'h22222222});
        end

        wq.delete();
        do_start();
        send_frame(f_basic, 1'b1, 5);
        end_frame(1'b0, 1'b0);
        chk("jit_n", 48'(wq.size()), 48'd1);
        if (wq.size() > 0) chk("jit_w0", wq[0], {16'h0010, 32'hDEADBEEF});

        wq.delete();
        do_start();
        for (int i = 0; i < 6; i++) send(f_basic[i], 0, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_flags",
            {42'd0, in_ready, busy, cpu_hold, done, err, wr_en}, 48'd0);
        chk("mid_rst_bus", {wr_addr, wr_data}, 48'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("mid_rst_nowr", 48'(wq.size()), 48'd0);
        chk("mid_rst_idle", {47'd0, busy}, 48'd0);
        do_start();
        send_frame(f_basic, 1'b0, -1);
        end_frame(1'b0, 1'b0);
        chk("post_rst_n", 48'(wq.size()), 48'd1);
        if (wq.size() > 0) chk("post_rst_w0", wq[0], {16'h0010, 32'hDEADBEEF});

        chk("hold_eq_busy", 48'(hold_bad), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
